// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcode values, the flag
// bundle layout and the arbiter FSM state encoding.
package alu_pkg;

    localparam logic [7:0] OP_ADD                = 8'd0;
    localparam logic [7:0] OP_SUBTRACT           = 8'd1;
    localparam logic [7:0] OP_MULTIPLY           = 8'd2;
    localparam logic [7:0] OP_EQUALS             = 8'd3;
    localparam logic [7:0] OP_GREATER_THAN       = 8'd4;
    localparam logic [7:0] OP_ADD_IMMEDIATE      = 8'd9;
    localparam logic [7:0] OP_SUBTRACT_IMMEDIATE = 8'd10;

    // Flag bundle, MSB first: {overflow, carry, zero, sign, parity}
    typedef struct packed {
        logic overflow;
        logic carry;
        logic zero;
        logic sign;
        logic parity;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: starting at the pointer index and
// wrapping upward, grant the first asserted request.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    idx_s;
    logic               found_s;

    // Walk the requesters in priority order beginning at the pointer
    always_comb begin
        int cand;
        grant_s = '0;
        idx_s   = '0;
        found_s = 1'b0;
        cand    = 32'sd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!found_s && req_i[cand]) begin
                grant_s[cand] = 1'b1;
                idx_s         = ID_W'(cand);
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant_o = grant_s;
    assign idx_o   = idx_s;
    assign any_o   = found_s;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU among NUM_REQ
// requesters. One operation at a time walks IDLE -> EXEC -> RESP; ALU drive
// and the response are held in flops so nothing downstream sees a glitch.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_opcode,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic                 alu_enable_out,
    output logic [7:0]           alu_opcode_out,
    output logic [7:0]           alu_a_out,
    output logic [7:0]           alu_b_out,
    input  logic [7:0]           alu_result_in,
    input  logic [4:0]           alu_flags_in,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [7:0]           resp_result,
    output logic [4:0]           resp_flags
);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             alu_en_q, alu_en_d;
    logic [7:0]       alu_op_q, alu_op_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic             resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    logic [7:0]       resp_result_q, resp_result_d;
    alu_flags_t       resp_flags_q, resp_flags_d;

    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    idx_s;
    logic               any_s;
    logic [ID_W+2:0]    sel_base_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .idx_o   (idx_s),
        .any_o   (any_s)
    );

    // Bit offset of the winner's byte lane in the packed request buses
    assign sel_base_s = {idx_s, 3'b000};

    // Grants are visible only while idle and never while reset is asserted
    assign req_ready = ((state_q == IDLE) && !reset_in) ? grant_s : '0;

    // Next-state and next-output computation for the three-phase operation
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        alu_en_d      = alu_en_q;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    state_d   = EXEC;
                    ptr_d     = (idx_s == ID_W'(NUM_REQ - 1)) ? '0 : idx_s + 1'b1;
                    alu_en_d  = 1'b1;
                    alu_op_d  = req_opcode[sel_base_s +: 8];
                    alu_a_d   = req_a[sel_base_s +: 8];
                    alu_b_d   = req_b[sel_base_s +: 8];
                    resp_id_d = idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // ALU inputs are live this cycle; its outputs are sampled raw
                state_d       = RESP;
                alu_en_d      = 1'b0;
                alu_op_d      = 8'h00;
                alu_a_d       = 8'h00;
                alu_b_d       = 8'h00;
                resp_valid_d  = 1'b1;
                resp_result_d = alu_result_in;
                resp_flags_d  = alu_flags_t'(alu_flags_in);
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                alu_en_d     = 1'b0;
                alu_op_d     = 8'h00;
                alu_a_d      = 8'h00;
                alu_b_d      = 8'h00;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State, pointer, ALU drive and response registers; reset drops any in-flight op
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            alu_en_q      <= 1'b0;
            alu_op_q      <= 8'h00;
            alu_a_q       <= 8'h00;
            alu_b_q       <= 8'h00;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= 8'h00;
            resp_flags_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            alu_en_q      <= alu_en_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
        end
    end

    assign alu_enable_out = alu_en_q;
    assign alu_opcode_out = alu_op_q;
    assign alu_a_out      = alu_a_q;
    assign alu_b_out      = alu_b_q;
    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_result    = resp_result_q;
    assign resp_flags     = resp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, scoreboard queue of expected
// responses filled at grant time and drained by a negedge monitor, directed
// scenarios followed by randomized traffic.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset_in;
    logic [N-1:0]   req_valid, req_ready;
    logic [8*N-1:0] req_opcode, req_a, req_b;
    logic           alu_enable_out;
    logic [7:0]     alu_opcode_out, alu_a_out, alu_b_out, alu_result_in;
    logic [4:0]     alu_flags_in;
    logic           resp_valid, resp_ready;
    logic [IW-1:0]  resp_id;
    logic [7:0]     resp_result;
    logic [4:0]     resp_flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clock_in(clk), .reset_in(reset_in),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .alu_enable_out(alu_enable_out), .alu_opcode_out(alu_opcode_out),
        .alu_a_out(alu_a_out), .alu_b_out(alu_b_out),
        .alu_result_in(alu_result_in), .alu_flags_in(alu_flags_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result), .resp_flags(resp_flags)
    );

    // Reference ALU: returns {flags[4:0], result[7:0]}
    function automatic logic [12:0] alu_ref(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  w;
        logic [15:0] m;
        logic [7:0]  r;
        logic        ov, cy;
        r = 8'h00; ov = 1'b0; cy = 1'b0;
        case (op)
            OP_ADD, OP_ADD_IMMEDIATE: begin
                w = {1'b0, a} + {1'b0, b}; r = w[7:0]; cy = w[8];
                ov = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUBTRACT, OP_SUBTRACT_IMMEDIATE: begin
                w = {1'b0, a} - {1'b0, b}; r = w[7:0]; cy = w[8];
                ov = (a[7] != b[7]) && (r[7] != a[7]);
            end
            OP_MULTIPLY: begin
                m = {8'h00, a} * {8'h00, b}; r = m[7:0]; cy = |m[15:8]; ov = cy;
            end
            OP_EQUALS:       r = (a == b) ? 8'd1 : 8'd0;
            OP_GREATER_THAN: r = (a > b) ? 8'd1 : 8'd0;
            default:         return 13'd0;
        endcase
        return {ov, cy, (r == 8'h00), r[7], ^r, r};
    endfunction

    // The ALU answers only when enabled; otherwise it shows a junk pattern
    always_comb begin
        if (alu_enable_out) {alu_flags_in, alu_result_in} = alu_ref(alu_opcode_out, alu_a_out, alu_b_out);
        else                {alu_flags_in, alu_result_in} = {5'h15, 8'hA5};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int         id;
        logic [7:0] op, a, b;
        logic [12:0] fr;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   ptr_m    = 0;
    int   cyc      = 0;
    bit   rst_seen = 1'b0;
    int   en_count = 0;

    // Monitor: reference arbitration model plus scoreboard of outstanding operations
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int   win;
        bit   exec_e, val_e;
        exp_t e;
        cyc++;
        if (alu_enable_out) en_count++;
        exp_rdy = '0;
        win = -1;
        if (!reset_in && sb.size() == 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ptr_m + k) % N;
                if (win < 0 && req_valid[c]) win = c;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        exec_e = (sb.size() == 1) && (cyc == sb[0].cyc + 1);
        chk("alu_enable", 64'(alu_enable_out), 64'(exec_e));
        if (exec_e)
            chk("alu_drive", 64'({alu_opcode_out, alu_a_out, alu_b_out}), 64'({sb[0].op, sb[0].a, sb[0].b}));
        else
            chk("alu_idle_zero", 64'({alu_opcode_out, alu_a_out, alu_b_out}), 64'd0);
        val_e = (sb.size() == 1) && (cyc >= sb[0].cyc + 2);
        chk("resp_valid", 64'(resp_valid), 64'(val_e));
        if (val_e) begin
            chk("resp_payload", 64'({resp_id, resp_flags, resp_result}), 64'({IW'(sb[0].id), sb[0].fr}));
            if (resp_ready) void'(sb.pop_front());
        end
        if (rst_seen)
            chk("reset_resp_zero", 64'({resp_id, resp_flags, resp_result}), 64'd0);
        rst_seen = reset_in;
        if (reset_in) begin
            sb.delete();
            ptr_m = 0;
        end else if (win >= 0) begin
            e.id  = win;
            e.op  = req_opcode[win*8 +: 8];
            e.a   = req_a[win*8 +: 8];
            e.b   = req_b[win*8 +: 8];
            e.fr  = alu_ref(e.op, e.a, e.b);
            e.cyc = cyc;
            sb.push_back(e);
            ptr_m = (win + 1) % N;
        end
    end

    function automatic logic [7:0] rand_op();
        logic [7:0] ops [9];
        ops = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd10, 8'd7, 8'hFF};
        rand_op = ops[$urandom_range(0, 8)];
        if (rand_op == 8'hFF) rand_op = 8'($urandom);
    endfunction

    task automatic check_all_zero(input string nm);
        chk({nm, "_ctl"}, 64'({req_ready, alu_enable_out, resp_valid, resp_id}), 64'd0);
        chk({nm, "_data"}, 64'({alu_opcode_out, alu_a_out, alu_b_out, resp_result, resp_flags}), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_in = 1'b1; req_valid = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_in = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");
    endtask

    task automatic dir_op(input int id, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int stall, input logic [7:0] exp_res, input logic [4:0] exp_fl, input string nm);
        @(posedge clk); #1;
        req_valid = '0; req_valid[id] = 1'b1;
        req_opcode[id*8 +: 8] = op; req_a[id*8 +: 8] = a; req_b[id*8 +: 8] = b;
        resp_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_ready"}, 64'(req_ready), 64'(1 << id));
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk({nm, "_exec_en"}, 64'({alu_enable_out, resp_valid}), 64'(2'b10));
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_resp"}, 64'({resp_valid, resp_id, resp_result, resp_flags}), 64'({1'b1, IW'(id), exp_res, exp_fl}));
        repeat (stall) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({nm, "_hold"}, 64'({resp_valid, resp_id, resp_result, resp_flags, req_ready, alu_enable_out}),
                64'({1'b1, IW'(id), exp_res, exp_fl, 4'b0000, 1'b0}));
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_last_resp"}, 64'(resp_valid), 64'd1);
        @(posedge clk); #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_back_idle"}, 64'({resp_valid, alu_enable_out}), 64'd0);
    endtask

    initial begin
        logic [N-1:0] g;
        int gid [5];
        int gc  [5];
        int exp_order [5];
        int gl, lc, e0;
        reset_in = 1'b1; req_valid = '0; resp_ready = 1'b0;
        req_opcode = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1 reset_in = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");

        // Round robin with every requester asserted
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            req_opcode[i*8 +: 8] = rand_op(); req_a[i*8 +: 8] = 8'($urandom); req_b[i*8 +: 8] = 8'($urandom);
        end
        req_valid = 4'hF; resp_ready = 1'b1;
        gl = 0; lc = 0; g = '0;
        exp_order = '{0, 1, 2, 3, 0};
        for (int t = 0; t < 30 && gl < 5; t++) begin
            @(negedge clk);
            lc++;
            g = req_ready;
            if (g != '0) begin
                for (int i = 0; i < N; i++) if (g[i]) gid[gl] = i;
                gc[gl] = lc;
                gl++;
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++)
                if (g[i]) begin
                    req_opcode[i*8 +: 8] = rand_op(); req_a[i*8 +: 8] = 8'($urandom);
                end
        end
        chk("rr_grant_count", 64'(gl), 64'd5);
        for (int i = 0; i < gl; i++) begin
            chk("rr_order", 64'(gid[i]), 64'(exp_order[i]));
            if (i > 0) chk("rr_spacing", 64'(gc[i] - gc[i-1]), 64'd3);
        end
        do_reset();

        dir_op(1, OP_ADD,      8'h7F, 8'h01, 0, 8'h80, 5'b10011, "add_ovf");
        dir_op(0, OP_SUBTRACT, 8'h00, 8'h01, 5, 8'hFF, 5'b01010, "sub_borrow");
        dir_op(3, OP_MULTIPLY, 8'h10, 8'h10, 0, 8'h00, 5'b11100, "mul_ovf");
        @(posedge clk); #1 e0 = en_count;
        dir_op(2, 8'h07,       8'h05, 8'h03, 1, 8'h00, 5'b00000, "undef_op");
        @(posedge clk); #1;
        chk("undef_enable_pulse", 64'(en_count - e0), 64'd1);

        // Reset asserted in the EXEC cycle drops the operation
        @(posedge clk); #1;
        req_valid[2] = 1'b1; req_opcode[23:16] = OP_ADD; req_a[23:16] = 8'h03; req_b[23:16] = 8'h04;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("rst_exec_ready", 64'(req_ready), 64'(4'b0100));
        @(posedge clk); #1 req_valid = '0; reset_in = 1'b1;
        @(negedge clk);
        chk("rst_exec_en", 64'({alu_enable_out, req_ready}), 64'(5'b10000));
        @(posedge clk); #1 reset_in = 1'b0;
        @(negedge clk);
        check_all_zero("rst_exec_after");
        repeat (5) begin
            @(negedge clk);
            chk("rst_exec_no_resp", 64'(resp_valid), 64'd0);
        end

        // Randomized traffic respecting the requester hold/advance rules
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            g = req_ready & req_valid;
            @(posedge clk); #1;
            if (reset_in) reset_in = 1'b0;
            else if ($urandom_range(0, 199) == 0) reset_in = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (g[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                    req_opcode[i*8 +: 8] = rand_op();
                    req_a[i*8 +: 8] = 8'($urandom);
                    req_b[i*8 +: 8] = 8'($urandom);
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1;
        req_valid = '0; reset_in = 1'b0; resp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
